imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//  Sequences the RV32I instruction memory at boot. Receives a byte-stream program image
//  (from the UART RX), packs it into 32-bit words and writes them into the instruction RAM.
//  Holds the core in reset during the load. Muxes the memory address port between loader
//  and CPU fetch, and releases the core once the image is complete.
// PARAMETERS
//  ADDR_W     8      word-address width; memory depth = 2**ADDR_W words (256 = 1KB)
//  SYNC_BYTE  8'hA5  frame-start byte
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       asynchronous active-low reset
//  rx_data      in   8       received byte
//  rx_valid     in   1       1-cycle strobe, rx_data valid
//  load_req     in   1       request re-load; honoured only in DONE/ERROR
//  cpu_addr     in   32      CPU fetch byte address
//  mem_we       out  1       instruction RAM write enable
//  mem_addr     out  ADDR_W  instruction RAM word address
//  mem_wdata    out  32      instruction RAM write data
//  core_rst_n   out  1       active-low reset to the CPU core
//  busy         out  1       loader owns the memory port
//  done         out  1       image loaded, core running
//  error        out  1       image rejected, core held in reset
//  words_loaded out  ADDR_W+1 words written in the current/last frame
// BEHAVIOUR
//  Reset values: state=IDLE; mem_we=0, mem_wdata=0, core_rst_n=0, busy=1, done=0,
//    error=0, words_loaded=0, byte/word pointers=0.
//  Reset is honoured at any point, mid-frame included: all state is cleared, partial words
//    are discarded, and core_rst_n goes low immediately.
//  States and transitions (each step consumes one rx_valid byte):
//    IDLE  - byte==SYNC_BYTE -> LEN0; other bytes ignored.
//    LEN0  - count[7:0]=byte -> LEN1.
//    LEN1  - count[15:8]=byte. Then: count==0 -> DONE; count>2**ADDR_W -> ERROR;
//            else -> DATA.
//    DATA  - bytes arrive little-endian: the first byte goes to [7:0], the 4th to [31:24].
//            On the 4th byte, mem_wdata is registered and mem_we pulses high for exactly
//            1 cycle, with mem_addr=wr_ptr (starting at 0). words_loaded increments in the
//            same cycle as the pulse, and wr_ptr increments after it. When the last word's
//            pulse occurs -> CHK (when CHECKSUM_EN is defined) else DONE.
//    DONE  - busy=0, done=1. core_rst_n=1 from the cycle after entry (registered).
//            rx_valid is ignored. load_req -> IDLE: core_rst_n=0 and done=0 in the same
//            cycle the state changes, and words_loaded is cleared.
//    ERROR - error=1, core_rst_n=0, busy=0. load_req -> IDLE and clears error.
//  load_req outside DONE/ERROR is ignored. rx_valid with no byte pending is a no-op.
//  mem_addr is combinational: busy ? wr_ptr : cpu_addr[ADDR_W+1:2]. mem_we is never high
//    while busy=0.
//  Simultaneous rx_valid and load_req in DONE: load_req wins, and that byte is dropped
//    (it is not a sync byte for the new frame).
//  There is no timeout: a stalled frame waits indefinitely until rst_n or completion.
// CONFIGURATION
//  IMEM_BOOT_CHECKSUM_EN defined:
//    - After the last word, state CHK expects one byte equal to the XOR of all data bytes
//      (length bytes excluded).
//    - Match -> DONE; mismatch -> ERROR. The words already written remain in RAM.
//  Not defined:
//    - CHK does not exist; DONE follows the last word directly, and no trailing byte is
//      expected.
// TESTING
//  1 Frame A5,02,00, 13,00,50,00, 93,01,10,00 -> two mem_we pulses: addr0=0x00500013,
//    addr1=0x00100193. words_loaded=2, done=1, core_rst_n=1 one cycle after DONE.
//  2 Frame A5,00,00 -> no mem_we; DONE; core released; mem_addr tracks cpu_addr[9:2]
//    (cpu_addr=0x8 -> 2).
//  3 Frame A5,01,01 (count 257 > 256) -> ERROR; error=1; core_rst_n stays 0; load_req
//    -> IDLE with error=0.
//  4 rst_n pulsed low after 6 data bytes -> core_rst_n=0 and words_loaded=0 at once;
//    new frame A5,01,00,EF,BE,AD,DE -> addr0=0xDEADBEEF.
//  5 In DONE, pulse load_req with rx_valid=1 (byte A5) -> IDLE, done=0, core_rst_n=0;
//    the A5 is dropped, so the frame needs a fresh A5.
//  6 (IMEM_BOOT_CHECKSUM_EN) frame of test 1 + byte 0xC1 -> DONE; same frame + 0x00
//    -> ERROR, words still written.

Source files
------------

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// Boot sequencer for the RV32I instruction memory. Receives a byte-stream program
// image, packs it into 32-bit little-endian words and writes them into the
// instruction RAM. The CPU core is held in reset while the image loads. The loader
// owns the RAM address port while busy, then hands it to CPU fetch.
//
// Frame format: SYNC_BYTE, count[7:0], count[15:8], then count*4 data bytes.
// Optional feature macro: IMEM_BOOT_CHECKSUM_EN. When it is defined, one trailing
// byte must equal the XOR of all data bytes.
//
// Handshake: rx_valid is a one-cycle strobe. The byte on rx_data is consumed in
// every cycle where rx_valid=1 and the current state accepts a byte. There is no
// backpressure, so bytes arriving in DONE/ERROR are dropped.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   rx_data       received byte
//   rx_valid      strobe for rx_data
//   load_req      re-load request, honoured in DONE/ERROR only
//   cpu_addr      CPU fetch byte address
//   mem_we        one-cycle RAM write pulse
//   mem_addr      RAM word address (loader pointer while busy, else CPU fetch)
//   mem_wdata     RAM write data
//   core_rst_n    active-low CPU reset
//   busy          loader owns the memory port
//   done          image loaded, core running
//   error         image rejected
//   words_loaded  words written in the current/last frame
//   dbg_state     current FSM state
module imem_boot_loader #(
    parameter int         ADDR_W    = 8,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              load_req,
    input  logic [31:0]       cpu_addr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded,
    output logic [2:0]        dbg_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN0  = 3'd1;
    localparam logic [2:0] S_LEN1  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;
`ifdef IMEM_BOOT_CHECKSUM_EN
    localparam logic [2:0] S_CHK   = 3'd6;
`endif

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    logic [2:0]        state;
    logic [15:0]       count;
    logic [1:0]        byte_ptr;
    logic [23:0]       shift;
    logic [ADDR_W-1:0] wr_ptr;
    logic [15:0]       new_count;
    logic              last_pulse;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [7:0]        xsum;
`endif

    // Only cpu_addr[ADDR_W+1:2] selects a word; the remaining bits are unused.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

    assign new_count  = {rx_data, count[7:0]};
    // The write pulse of the final word. The state leaves DATA at the end of this
    // cycle, so busy stays high for the whole pulse.
    assign last_pulse = mem_we && (16'(words_loaded) == count);

    assign busy      = (state != S_DONE) && (state != S_ERROR);
    assign done      = (state == S_DONE);
    assign error     = (state == S_ERROR);
    assign mem_addr  = busy ? wr_ptr : cpu_addr[ADDR_W+1:2];
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            count        <= '0;
            byte_ptr     <= '0;
            shift        <= '0;
            wr_ptr       <= '0;
            words_loaded <= '0;
            mem_we       <= 1'b0;
            mem_wdata    <= '0;
            core_rst_n   <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            xsum         <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            if (mem_we) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            // Released one cycle after DONE entry. Pulled low on the same edge that
            // load_req takes the FSM back to IDLE.
            core_rst_n <= (state == S_DONE) && !load_req;

            case (state)
                S_IDLE: begin
                    if (rx_valid && (rx_data == SYNC_BYTE)) begin
                        state        <= S_LEN0;
                        byte_ptr     <= '0;
                        wr_ptr       <= '0;
                        words_loaded <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
                        xsum         <= '0;
`endif
                    end
                end
                S_LEN0: begin
                    if (rx_valid) begin
                        count[7:0] <= rx_data;
                        state      <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (rx_valid) begin
                        count[15:8] <= rx_data;
                        if (new_count == 16'd0) begin
                            state <= S_DONE;
                        end else if ({1'b0, new_count} > MAX_WORDS) begin
                            state <= S_ERROR;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (last_pulse) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                        // A checksum byte can arrive in the same cycle as the
                        // final write pulse.
                        if (rx_valid) begin
                            state <= (rx_data == xsum) ? S_DONE : S_ERROR;
                        end else begin
                            state <= S_CHK;
                        end
`else
                        state <= S_DONE;
`endif
                    end else if (rx_valid) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                        xsum <= xsum ^ rx_data;
`endif
                        byte_ptr <= byte_ptr + 1'b1;
                        if (byte_ptr == 2'd3) begin
                            mem_we       <= 1'b1;
                            mem_wdata    <= {rx_data, shift};
                            words_loaded <= words_loaded + 1'b1;
                        end else begin
                            shift[{byte_ptr, 3'b000} +: 8] <= rx_data;
                        end
                    end
                end
`ifdef IMEM_BOOT_CHECKSUM_EN
                S_CHK: begin
                    if (rx_valid) begin
                        state <= (rx_data == xsum) ? S_DONE : S_ERROR;
                    end
                end
`endif
                S_DONE: begin
                    if (load_req) begin
                        state        <= S_IDLE;
                        words_loaded <= '0;
                    end
                end
                S_ERROR: begin
                    if (load_req) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              load_req;
    logic [31:0]       cpu_addr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_rst_n;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;
    logic [2:0]        dbg_state;

    imem_boot_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .load_req(load_req), .cpu_addr(cpu_addr), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_rst_n(core_rst_n),
        .busy(busy), .done(done), .error(error), .words_loaded(words_loaded),
        .dbg_state(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Expected RAM writes {word address, data}, in order.
    logic [ADDR_W+31:0] exp_q[$];
    logic [31:0]        frame_words[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_we === 1'b1) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_write observed=%h_%h expected=none", mem_addr, mem_wdata);
            end
            if (exp_q.size() > 0) begin
                logic [ADDR_W+31:0] e;
                e = exp_q.pop_front();
                checks++;
                assert ({mem_addr, mem_wdata} === e) else begin
                    failures++;
                    $error("FAIL write observed=%h_%h expected=%h_%h",
                           mem_addr, mem_wdata, e[ADDR_W+31:32], e[31:0]);
                end
            end
            checks++;
            assert (busy === 1'b1) else begin
                failures++;
                $error("FAIL we_while_idle observed busy=%b expected=1", busy);
            end
        end
    end

    // driver tasks
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_load();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    // Sends a whole frame built from frame_words and queues the expected writes.
    // Junk bytes before the sync byte must be ignored in IDLE.
    task automatic load_words(input bit gaps, input bit bad_chk);
        logic [15:0] n;
        logic [7:0]  xs;
        logic [7:0]  b;
        n  = 16'(frame_words.size());
        xs = 8'h00;
        repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h00;
            send_byte(b, 0);
        end
        send_byte(8'hA5, 0);
        send_byte(n[7:0], gaps ? $urandom_range(0, 2) : 0);
        send_byte(n[15:8], gaps ? $urandom_range(0, 2) : 0);
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back({ADDR_W'(i), frame_words[i]});
            for (int k = 0; k < 4; k++) begin
                b  = frame_words[i][8*k +: 8];
                xs = xs ^ b;
                send_byte(b, gaps ? $urandom_range(0, 2) : 0);
            end
        end
`ifdef IMEM_BOOT_CHECKSUM_EN
        if (n != 16'd0) begin
            send_byte(bad_chk ? 8'h00 : xs, gaps ? $urandom_range(0, 2) : 0);
        end
`else
        if (bad_chk) xs = 8'h00;
`endif
    endtask

    // Bounded wait for DONE, then check the release timing and final status.
    task automatic wait_done(input int exp_words, input string tag);
        int t;
        t = 0;
        while (done !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_core_rst_entry"}, 32'(core_rst_n), 32'd0);
        @(negedge clk);
        chk({tag, "_core_rst_rel"}, 32'(core_rst_n), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_words"}, 32'(words_loaded), 32'(exp_words));
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reload(input string tag);
        chk({tag, "_done0"}, 32'(done), 32'd0);
        chk({tag, "_core_rst0"}, 32'(core_rst_n), 32'd0);
        chk({tag, "_busy1"}, 32'(busy), 32'd1);
        chk({tag, "_words0"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        load_req = 1'b0;
        cpu_addr = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_core_rst", 32'(core_rst_n), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        rst_n = 1'b1;

        // Two-word directed frame.
        frame_words = '{32'h00500013, 32'h00100193};
        load_words(1'b0, 1'b0);
        wait_done(2, "t1");
        // Bytes in DONE are ignored (scoreboard flags any write).
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        repeat (3) @(negedge clk);
        chk("t1_done_hold", 32'(done), 32'd1);
        cpu_addr = $urandom;
        #1;
        chk("t1_fetch_addr", 32'(mem_addr), 32'(cpu_addr[ADDR_W+1:2]));

        // Empty frame.
        pulse_load();
        check_reload("t2_reload");
        frame_words = {};
        load_words(1'b0, 1'b0);
        wait_done(0, "t2");
        cpu_addr = 32'h8;
        #1;
        chk("t2_fetch_addr", 32'(mem_addr), 32'd2);

        // Oversized count is rejected.
        pulse_load();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        chk("t3_error", 32'(error), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("t3_core_rst", 32'(core_rst_n), 32'd0);
        pulse_load();
        chk("t3_error_clr", 32'(error), 32'd0);
        chk("t3_busy_idle", 32'(busy), 32'd1);

        // Reset mid-frame: first word written, partial second discarded.
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        exp_q.push_back({ADDR_W'(0), 32'h04030201});
        for (int k = 1; k <= 6; k++) send_byte(8'(k), 0);
        chk("t4_words_pre", 32'(words_loaded), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t4_core_rst", 32'(core_rst_n), 32'd0);
        chk("t4_words", 32'(words_loaded), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        frame_words = '{32'hDEADBEEF};
        load_words(1'b0, 1'b0);
        wait_done(1, "t4");

        // load_req and rx_valid together in DONE: the A5 is dropped.
        @(negedge clk);
        load_req = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        @(negedge clk);
        load_req = 1'b0;
        rx_valid = 1'b0;
        check_reload("t5");
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        repeat (3) @(negedge clk);
        chk("t5_a5_dropped", 32'(done), 32'd0);
        frame_words = '{$urandom};
        load_words(1'b1, 1'b0);
        wait_done(1, "t5");

        // Randomised frames with random byte gaps.
        for (int r = 0; r < 6; r++) begin
            int n;
            pulse_load();
            n = $urandom_range(1, 6);
            frame_words = {};
            for (int i = 0; i < n; i++) frame_words.push_back($urandom);
            load_words(1'b1, 1'b0);
            wait_done(n, "rand");
            cpu_addr = $urandom;
            #1;
            chk("rand_fetch_addr", 32'(mem_addr), 32'(cpu_addr[ADDR_W+1:2]));
        end

        // Full-depth frame.
        pulse_load();
        frame_words = {};
        for (int i = 0; i < 256; i++) frame_words.push_back($urandom);
        load_words(1'b0, 1'b0);
        wait_done(256, "full");

`ifdef IMEM_BOOT_CHECKSUM_EN
        // Checksum match and mismatch.
        pulse_load();
        frame_words = '{32'h00500013, 32'h00100193};
        load_words(1'b0, 1'b0);
        wait_done(2, "t6_ok");
        pulse_load();
        load_words(1'b0, 1'b1);
        chk("t6_bad_error", 32'(error), 32'd1);
        chk("t6_bad_core_rst", 32'(core_rst_n), 32'd0);
        chk("t6_bad_written", 32'(exp_q.size()), 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
